int_issue_queue: RTL and testbench
==================================

Name: int_issue_queue

Overview:
- Integer reservation station directly downstream of the dispatcher.
- Accepts one decoded ALU instruction per cycle, holding renamed source operands as either data or a producer tag.
- Snoops the common data bus (CDB) to wake up waiting operands.
- Issues one fully-ready instruction per cycle to the integer ALU through a valid/ready handshake. Flushed on branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries (power of two, 2..16)
- TAG_W, 6, physical/ROB tag width
- DATA_W, 32, operand width
- OP_W, 4, ALU operation code width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  discard all entries (branch/jump redirect)
- i_disp_valid  in  1  dispatcher presents an instruction
- i_disp_alu_op  in  OP_W  ALU operation
- i_disp_rd_tag  in  TAG_W  destination tag
- i_disp_rs1_rdy  in  1  rs1 data valid at dispatch
- i_disp_rs1_tag  in  TAG_W  rs1 producer tag (used when not ready)
- i_disp_rs1_data  in  DATA_W  rs1 value (used when ready)
- i_disp_rs2_rdy / i_disp_rs2_tag / i_disp_rs2_data  in  1/TAG_W/DATA_W  same for rs2 (immediate arrives here, ready=1)
- o_full  out  1  no free entry; dispatcher stalls
- o_count  out  $clog2(DEPTH+1)  occupied entries
- i_cdb_valid  in  1  CDB broadcast valid
- i_cdb_tag  in  TAG_W  broadcast tag
- i_cdb_data  in  DATA_W  broadcast value
- o_issue_valid  out  1  an entry has both operands ready
- i_issue_ready  in  1  ALU accepts
- o_issue_alu_op / o_issue_rd_tag  out  OP_W/TAG_W  issued entry fields
- o_issue_rs1_data / o_issue_rs2_data  out  DATA_W  issued operands

Behaviour:
- Reset (async, i_rst_n=0): all entry valid bits cleared.
  - o_full=0, o_count=0, o_issue_valid=0, all o_issue_* data/tag/op=0.
  - Reset mid-operation discards all entries immediately.
- Entry fields: valid, op, rd_tag, and per source {rdy, tag, data}.
- Dispatch: accepted at the clock edge when i_disp_valid=1 and o_full=0 (registered full) and i_flush=0.
  - Written into the lowest-index free entry.
  - Dispatch while o_full=1 is ignored, even if an issue frees a slot in the same cycle; the slot becomes usable the next cycle.
- Dispatch/CDB bypass: if a dispatched source has rdy=0 and i_cdb_valid=1 with i_cdb_tag equal to its tag in the same cycle, the entry stores rdy=1 and data=i_cdb_data.
- Wake-up: every valid entry compares both waiting sources against the CDB each cycle.
  - On a match, it captures the data and sets rdy at that edge.
  - One CDB value may wake any number of sources/entries.
- Select (combinational from registered state): o_issue_valid=1 if any valid entry has rs1.rdy & rs2.rdy.
  - The lowest-index such entry drives the o_issue_* outputs.
  - When none is ready, the o_issue_* outputs are driven to 0.
  - Minimum latency: dispatch of a fully-ready instruction at edge N gives o_issue_valid in cycle N+1.
  - CDB wake-up at edge N gives issue eligibility in cycle N+1. There is no same-cycle CDB-to-issue forwarding.
- Issue: at an edge with o_issue_valid & i_issue_ready, the selected entry's valid bit clears.
  - The outputs hold stable while valid=1 and ready=0, unless a lower-index entry becomes ready; the lowest-index ready entry always wins.
- Count: o_count = number of valid entries, updated +1 on dispatch and −1 on issue; net 0 when both occur in the same cycle. o_full = (o_count==DEPTH).
- Flush: i_flush=1 clears all entries at the edge.
  - It dominates dispatch and issue in the same cycle.
  - The ALU still sees o_issue_valid during the flush cycle; the ALU gates on flush.
- Tag 0 is not special; a CDB with i_cdb_valid=0 never matches.

Decomposition:
- Package int_rs_pkg: TAG_W/DATA_W/OP_W constants, ALU op enum, packed struct for a source operand {rdy, tag, data} and for an entry {valid, op, rd_tag, src1, src2}.
- Sub-module int_rs_entry: one entry holding the registers for dispatch write, CDB wake-up compare/capture and issue clear, plus a ready output.
- The top-level instantiates DEPTH entries with a generate loop and contains:
  - free-slot and ready-slot lowest-index priority encoders
  - the count register
  - the output mux

Test Plan:
- Reset, then dispatch add (op=0, rd_tag=5, rs1 rdy data=3, rs2 rdy data=4) -> next cycle o_issue_valid=1, rs1=3, rs2=4, rd_tag=5; with ready=1, o_count goes 1->0.
- Dispatch rs1 waiting tag=9 -> no issue; CDB tag=9 data=0xDEAD at edge N -> o_issue_valid at N+1 with rs1=0xDEAD; CDB tag=8 produces no wake.
- Same-cycle dispatch (rs2 waiting tag=12) and CDB tag=12 data=7 -> entry ready, issues next cycle with rs2=7.
- Fill 4 entries with ready=0 held -> o_full=1, o_count=4; a 5th dispatch is dropped; issue one -> o_full=0 next cycle, entry 0 issued first (lowest index).
- 3 entries occupied, assert i_flush together with i_disp_valid -> next cycle o_count=0, o_issue_valid=0, dispatched instruction lost.
- Drop i_rst_n asynchronously with 2 entries ready and ready=0 -> outputs zero immediately, before the next clock edge.

Source files
------------

// File: rtl/int_rs_pkg.sv
// Shared widths, operand/entry types and the CDB wake-up helper for the
// integer reservation station.
package int_rs_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } src_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] rd_tag;
    src_t             src1;
    src_t             src2;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // A waiting source captures the broadcast value when its producer tag matches.
  function automatic src_t src_wake(input src_t s, input logic cdb_valid,
                                    input logic [TAG_W-1:0] cdb_tag,
                                    input logic [DATA_W-1:0] cdb_data);
    src_t r;
    r = s;
    if (!s.rdy && cdb_valid && (s.tag == cdb_tag)) begin
      r.rdy  = 1'b1;
      r.data = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_rs_entry.sv
// One reservation-station slot: dispatch write with CDB bypass, per-cycle
// wake-up of waiting sources, and clear on issue or flush.
module int_rs_entry
  import int_rs_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_entry,
  input  logic               i_cdb_valid,
  input  logic [TAG_W-1:0]   i_cdb_tag,
  input  logic [DATA_W-1:0]  i_cdb_data,
  input  logic               i_issue_clr,
  output logic               o_valid,
  output logic               o_ready,
  output logic [OP_W-1:0]    o_op,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [DATA_W-1:0]  o_rs1_data,
  output logic [DATA_W-1:0]  o_rs2_data
);

  entry_t entry_q, entry_d, wr_entry;

  assign wr_entry = entry_t'(i_wr_entry);

  always_comb begin
    entry_d = entry_q;
    if (entry_q.valid) begin
      entry_d.src1 = src_wake(entry_q.src1, i_cdb_valid, i_cdb_tag, i_cdb_data);
      entry_d.src2 = src_wake(entry_q.src2, i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
    if (i_issue_clr) begin
      entry_d.valid = 1'b0;
    end
    if (i_wr_en) begin
      entry_d      = wr_entry;
      entry_d.src1 = src_wake(wr_entry.src1, i_cdb_valid, i_cdb_tag, i_cdb_data);
      entry_d.src2 = src_wake(wr_entry.src2, i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
    // Redirect wins over everything else happening this cycle.
    if (i_flush) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign o_valid    = entry_q.valid;
  assign o_ready    = entry_q.valid & entry_q.src1.rdy & entry_q.src2.rdy;
  assign o_op       = entry_q.op;
  assign o_rd_tag   = entry_q.rd_tag;
  assign o_rs1_data = entry_q.src1.data;
  assign o_rs2_data = entry_q.src2.data;

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation station: DEPTH slots, lowest-free dispatch placement,
// lowest-ready issue select, occupancy count and flush.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = int_rs_pkg::TAG_W,
  parameter int DATA_W = int_rs_pkg::DATA_W,
  parameter int OP_W   = int_rs_pkg::OP_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_disp_valid,
  input  logic [OP_W-1:0]            i_disp_alu_op,
  input  logic [TAG_W-1:0]           i_disp_rd_tag,
  input  logic                       i_disp_rs1_rdy,
  input  logic [TAG_W-1:0]           i_disp_rs1_tag,
  input  logic [DATA_W-1:0]          i_disp_rs1_data,
  input  logic                       i_disp_rs2_rdy,
  input  logic [TAG_W-1:0]           i_disp_rs2_tag,
  input  logic [DATA_W-1:0]          i_disp_rs2_data,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  input  logic                       i_cdb_valid,
  input  logic [TAG_W-1:0]           i_cdb_tag,
  input  logic [DATA_W-1:0]          i_cdb_data,
  output logic                       o_issue_valid,
  input  logic                       i_issue_ready,
  output logic [OP_W-1:0]            o_issue_alu_op,
  output logic [TAG_W-1:0]           o_issue_rd_tag,
  output logic [DATA_W-1:0]          o_issue_rs1_data,
  output logic [DATA_W-1:0]          o_issue_rs2_data
);

  import int_rs_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  ent_valid, ent_ready;
  logic [OP_W-1:0]   ent_op   [DEPTH];
  logic [TAG_W-1:0]  ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_rs1  [DEPTH];
  logic [DATA_W-1:0] ent_rs2  [DEPTH];
  logic [IDX_W-1:0]  free_idx, rdy_idx;
  logic              free_found, rdy_found;
  logic              disp_fire, issue_fire;
  entry_t            wr_entry;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent_ready[i]) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  // Full is taken from the registered count, so a slot freed by this cycle's
  // issue only becomes available to dispatch on the following cycle.
  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_count    = count_q;
  assign disp_fire  = i_disp_valid & ~o_full & ~i_flush & free_found;
  assign issue_fire = rdy_found & i_issue_ready & ~i_flush;

  always_comb begin
    wr_entry           = '0;
    wr_entry.valid     = 1'b1;
    wr_entry.op        = i_disp_alu_op;
    wr_entry.rd_tag    = i_disp_rd_tag;
    wr_entry.src1.rdy  = i_disp_rs1_rdy;
    wr_entry.src1.tag  = i_disp_rs1_tag;
    wr_entry.src1.data = i_disp_rs1_data;
    wr_entry.src2.rdy  = i_disp_rs2_rdy;
    wr_entry.src2.tag  = i_disp_rs2_tag;
    wr_entry.src2.data = i_disp_rs2_data;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      int_rs_entry u_entry (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_wr_en     (disp_fire && (free_idx == IDX_W'(gi))),
        .i_wr_entry  (wr_entry),
        .i_cdb_valid (i_cdb_valid),
        .i_cdb_tag   (i_cdb_tag),
        .i_cdb_data  (i_cdb_data),
        .i_issue_clr (issue_fire && (rdy_idx == IDX_W'(gi))),
        .o_valid     (ent_valid[gi]),
        .o_ready     (ent_ready[gi]),
        .o_op        (ent_op[gi]),
        .o_rd_tag    (ent_rd[gi]),
        .o_rs1_data  (ent_rs1[gi]),
        .o_rs2_data  (ent_rs2[gi])
      );
    end
  endgenerate

  always_comb begin
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    if (i_flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_issue_valid    = rdy_found;
  assign o_issue_alu_op   = rdy_found ? ent_op[rdy_idx]  : '0;
  assign o_issue_rd_tag   = rdy_found ? ent_rd[rdy_idx]  : '0;
  assign o_issue_rs1_data = rdy_found ? ent_rs1[rdy_idx] : '0;
  assign o_issue_rs2_data = rdy_found ? ent_rs2[rdy_idx] : '0;

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed scoreboard bench for int_issue_queue: stimulus queues the expected
// issued instructions, a negedge monitor pops and compares on each handshake.
module tb_int_issue_queue;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_disp_valid;
  logic [3:0]  i_disp_alu_op;
  logic [5:0]  i_disp_rd_tag;
  logic        i_disp_rs1_rdy;
  logic [5:0]  i_disp_rs1_tag;
  logic [31:0] i_disp_rs1_data;
  logic        i_disp_rs2_rdy;
  logic [5:0]  i_disp_rs2_tag;
  logic [31:0] i_disp_rs2_data;
  logic        o_full;
  logic [2:0]  o_count;
  logic        i_cdb_valid;
  logic [5:0]  i_cdb_tag;
  logic [31:0] i_cdb_data;
  logic        o_issue_valid;
  logic        i_issue_ready;
  logic [3:0]  o_issue_alu_op;
  logic [5:0]  o_issue_rd_tag;
  logic [31:0] o_issue_rs1_data;
  logic [31:0] o_issue_rs2_data;

  int_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OP_W(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_flush          (i_flush),
    .i_disp_valid     (i_disp_valid),
    .i_disp_alu_op    (i_disp_alu_op),
    .i_disp_rd_tag    (i_disp_rd_tag),
    .i_disp_rs1_rdy   (i_disp_rs1_rdy),
    .i_disp_rs1_tag   (i_disp_rs1_tag),
    .i_disp_rs1_data  (i_disp_rs1_data),
    .i_disp_rs2_rdy   (i_disp_rs2_rdy),
    .i_disp_rs2_tag   (i_disp_rs2_tag),
    .i_disp_rs2_data  (i_disp_rs2_data),
    .o_full           (o_full),
    .o_count          (o_count),
    .i_cdb_valid      (i_cdb_valid),
    .i_cdb_tag        (i_cdb_tag),
    .i_cdb_data       (i_cdb_data),
    .o_issue_valid    (o_issue_valid),
    .i_issue_ready    (i_issue_ready),
    .o_issue_alu_op   (o_issue_alu_op),
    .o_issue_rd_tag   (o_issue_rd_tag),
    .o_issue_rs1_data (o_issue_rs1_data),
    .o_issue_rs2_data (o_issue_rs2_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [3:0] op, input logic [5:0] rd,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op = op; e.rd = rd; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted handshake must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && !i_flush && o_issue_valid && i_issue_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: got rd=%0d expected no issue", o_issue_rd_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("issue op=%0d rd=%0d rs1=0x%0h rs2=0x%0h", o_issue_alu_op,
                 o_issue_rd_tag, o_issue_rs1_data, o_issue_rs2_data);
        chk("issue_op",  64'(o_issue_alu_op),   64'(e.op));
        chk("issue_rd",  64'(o_issue_rd_tag),   64'(e.rd));
        chk("issue_rs1", 64'(o_issue_rs1_data), 64'(e.a));
        chk("issue_rs2", 64'(o_issue_rs2_data), 64'(e.b));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                      input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    i_disp_valid    = 1'b1;
    i_disp_alu_op   = op;
    i_disp_rd_tag   = rd;
    i_disp_rs1_rdy  = r1;
    i_disp_rs1_tag  = t1;
    i_disp_rs1_data = d1;
    i_disp_rs2_rdy  = r2;
    i_disp_rs2_tag  = t2;
    i_disp_rs2_data = d2;
  endtask

  task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    i_cdb_valid = v;
    i_cdb_tag   = t;
    i_cdb_data  = d;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_issue_ready = 1'b0;
    disp(4'd0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    i_disp_valid = 1'b0;
    cdb(1'b0, 6'd0, 32'd0);
    #2;
    chk("reset_full",  64'(o_full), 64'd0);
    chk("reset_count", 64'(o_count), 64'd0);
    chk("reset_valid", 64'(o_issue_valid), 64'd0);
    chk("reset_rs1",   64'(o_issue_rs1_data), 64'd0);
    #10;
    i_rst_n = 1'b1;
    tick();

    // Fully-ready add issues the cycle after dispatch.
    disp(4'd0, 6'd5, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
    tick();
    i_disp_valid = 1'b0;
    chk("add_count", 64'(o_count), 64'd1);
    chk("add_valid", 64'(o_issue_valid), 64'd1);
    expect_issue(4'd0, 6'd5, 32'd3, 32'd4);
    i_issue_ready = 1'b1;
    tick();
    i_issue_ready = 1'b0;
    chk("add_count_after", 64'(o_count), 64'd0);
    chk("add_valid_after", 64'(o_issue_valid), 64'd0);

    // rs1 waits on tag 9; invalid CDB and wrong tag must not wake it.
    disp(4'd1, 6'd6, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd10);
    tick();
    i_disp_valid = 1'b0;
    chk("wait_valid", 64'(o_issue_valid), 64'd0);
    cdb(1'b0, 6'd9, 32'h1234);
    tick();
    chk("cdb_invalid_nowake", 64'(o_issue_valid), 64'd0);
    cdb(1'b1, 6'd8, 32'h1111);
    tick();
    chk("cdb_tag8_nowake", 64'(o_issue_valid), 64'd0);
    cdb(1'b1, 6'd9, 32'h0000DEAD);
    tick();
    cdb(1'b0, 6'd0, 32'd0);
    chk("wake_valid", 64'(o_issue_valid), 64'd1);
    expect_issue(4'd1, 6'd6, 32'h0000DEAD, 32'd10);
    i_issue_ready = 1'b1;
    tick();
    i_issue_ready = 1'b0;
    chk("wake_count_after", 64'(o_count), 64'd0);

    // Dispatch/CDB bypass in the same cycle.
    disp(4'd2, 6'd7, 1'b1, 6'd0, 32'd20, 1'b0, 6'd12, 32'd0);
    cdb(1'b1, 6'd12, 32'd7);
    tick();
    i_disp_valid = 1'b0;
    cdb(1'b0, 6'd0, 32'd0);
    chk("bypass_valid", 64'(o_issue_valid), 64'd1);
    expect_issue(4'd2, 6'd7, 32'd20, 32'd7);
    i_issue_ready = 1'b1;
    tick();
    i_issue_ready = 1'b0;

    // Fill all four slots, drop a fifth, then check freed slot reuse timing.
    for (int k = 1; k <= 4; k++) begin
      disp(4'd3, 6'(k), 1'b1, 6'd0, 32'(100 + k), 1'b1, 6'd0, 32'(k));
      tick();
    end
    chk("fill_full",  64'(o_full), 64'd1);
    chk("fill_count", 64'(o_count), 64'd4);
    disp(4'd3, 6'd15, 1'b1, 6'd0, 32'd115, 1'b1, 6'd0, 32'd15);
    tick();
    chk("drop_count", 64'(o_count), 64'd4);
    chk("hold_rd",    64'(o_issue_rd_tag), 64'd1);
    expect_issue(4'd3, 6'd1, 32'd101, 32'd1);
    i_issue_ready = 1'b1;
    tick();
    i_issue_ready = 1'b0;
    chk("issue_while_full_count", 64'(o_count), 64'd3);
    chk("issue_while_full_full",  64'(o_full), 64'd0);
    tick();
    i_disp_valid = 1'b0;
    chk("refill_count", 64'(o_count), 64'd4);
    chk("refill_low_index", 64'(o_issue_rd_tag), 64'd15);
    expect_issue(4'd3, 6'd15, 32'd115, 32'd15);
    expect_issue(4'd3, 6'd2,  32'd102, 32'd2);
    expect_issue(4'd3, 6'd3,  32'd103, 32'd3);
    expect_issue(4'd3, 6'd4,  32'd104, 32'd4);
    i_issue_ready = 1'b1;
    repeat (4) tick();
    i_issue_ready = 1'b0;
    chk("drain_count", 64'(o_count), 64'd0);

    // Flush together with dispatch loses everything.
    for (int k = 0; k < 3; k++) begin
      disp(4'd4, 6'(20 + k), 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd1);
      tick();
    end
    chk("pre_flush_count", 64'(o_count), 64'd3);
    disp(4'd4, 6'd25, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_disp_valid = 1'b0;
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_issue_valid), 64'd0);
    cdb(1'b1, 6'd30, 32'h55);
    tick();
    cdb(1'b0, 6'd0, 32'd0);
    chk("flush_no_revive", 64'(o_issue_valid), 64'd0);

    // Asynchronous reset with ready entries pending.
    disp(4'd5, 6'd40, 1'b1, 6'd0, 32'hA, 1'b1, 6'd0, 32'hB);
    tick();
    disp(4'd5, 6'd41, 1'b1, 6'd0, 32'hC, 1'b1, 6'd0, 32'hD);
    tick();
    i_disp_valid = 1'b0;
    chk("prereset_count", 64'(o_count), 64'd2);
    chk("prereset_rd",    64'(o_issue_rd_tag), 64'd40);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(o_issue_valid), 64'd0);
    chk("async_count", 64'(o_count), 64'd0);
    chk("async_rd",    64'(o_issue_rd_tag), 64'd0);
    chk("async_rs1",   64'(o_issue_rs1_data), 64'd0);
    #3;
    i_rst_n = 1'b1;
    tick();
    chk("post_reset_count", 64'(o_count), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
